imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 138 +++++++++++++
 tb/tb_imem_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// imem_responder
//   Single-outstanding instruction-fetch responder backed by a word-addressed
//   program memory. A fetch is accepted when iReq && oReady. The response
//   appears LATENCY cycles later and is held until iRespReady. Misaligned or
//   out-of-range fetches return NOP_WORD with oFault set. iFlush drops the
//   outstanding fetch. The memory is loaded through an independent write port
//   (iWrEn/iWrAddr/iWrData) and is not cleared by reset.
//
// Ports
//   iClk, nRst          clock, asynchronous active-low reset
//   iReq, iAddr, oReady fetch request handshake (byte address)
//   oValid, iRespReady  response handshake
//   oIns, oRespAddr     response word and the byte address it answers
//   oFault              response belongs to a faulting fetch
//   iFlush              discard the outstanding fetch, block acceptance
//   iWrEn, iWrAddr,
//   iWrData             program-load write port (byte address, bits [1:0] ignored)
module imem_responder #(
  parameter int unsigned ADDR_WORDS = 1024,
  parameter int unsigned LATENCY    = 2,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic        iClk,
  input  logic        nRst,
  input  logic        iReq,
  input  logic [31:0] iAddr,
  output logic        oReady,
  output logic        oValid,
  input  logic        iRespReady,
  output logic [31:0] oIns,
  output logic [31:0] oRespAddr,
  output logic        oFault,
  input  logic        iFlush,
  input  logic        iWrEn,
  input  logic [31:0] iWrAddr,
  input  logic [31:0] iWrData
);

  localparam int unsigned AW = $clog2(ADDR_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [31:0] mem [ADDR_WORDS];

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] ins_q,   ins_d;
  logic        fault_q, fault_d;

  logic        accept;
  logic        fetch_fault;
  logic        wr_in_range;
  logic        unused_wr_lsb;

  assign unused_wr_lsb = ^iWrAddr[1:0];

  assign fetch_fault = (iAddr[1:0] != 2'b00) ||
                       ({2'b00, iAddr[31:2]} >= 32'(ADDR_WORDS));
  assign wr_in_range = ({2'b00, iWrAddr[31:2]} < 32'(ADDR_WORDS));

  assign oReady = !iFlush &&
                  ((state_q == S_IDLE) || ((state_q == S_RESP) && iRespReady));
  assign accept = iReq && oReady;

  assign oValid    = (state_q == S_RESP);
  assign oIns      = oValid ? ins_q : '0;
  assign oFault    = oValid && fault_q;
  assign oRespAddr = addr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ins_d   = ins_q;
    fault_d = fault_q;

    if (accept) begin
      // Read happens in the accepting cycle, so a same-cycle write to the
      // same word is not seen by this fetch.
      addr_d  = iAddr;
      fault_d = fetch_fault;
      ins_d   = fetch_fault ? NOP_WORD : mem[iAddr[AW+1:2]];
      if (LATENCY <= 1) begin
        state_d = S_RESP;
        cnt_d   = '0;
      end else begin
        state_d = S_WAIT;
        cnt_d   = 4'(LATENCY - 1);
      end
    end else begin
      case (state_q)
        S_IDLE: ;
        S_WAIT: begin
          if (iFlush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q <= 4'd1) begin
            state_d = S_RESP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (iFlush || iRespReady) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      ins_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ins_q   <= ins_d;
      fault_q <= fault_d;
    end
  end

  always_ff @(posedge iClk) begin
    if (iWrEn && wr_in_range) mem[iWrAddr[AW+1:2]] <= iWrData;
  end

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  logic        iClk = 1'b0;
  logic        nRst;
  logic        iReq;
  logic [31:0] iAddr;
  logic        oReady;
  logic        oValid;
  logic        iRespReady;
  logic [31:0] oIns;
  logic [31:0] oRespAddr;
  logic        oFault;
  logic        iFlush;
  logic        iWrEn;
  logic [31:0] iWrAddr;
  logic [31:0] iWrData;

  int checks   = 0;
  int failures = 0;

  imem_responder #(
    .ADDR_WORDS(1024),
    .LATENCY   (2),
    .NOP_WORD  (32'h0000_0013)
  ) dut (
    .iClk      (iClk),
    .nRst      (nRst),
    .iReq      (iReq),
    .iAddr     (iAddr),
    .oReady    (oReady),
    .oValid    (oValid),
    .iRespReady(iRespReady),
    .oIns      (oIns),
    .oRespAddr (oRespAddr),
    .oFault    (oFault),
    .iFlush    (iFlush),
    .iWrEn     (iWrEn),
    .iWrAddr   (iWrAddr),
    .iWrData   (iWrData)
  );

  always #5 iClk = ~iClk;

  // Advance one clock; inputs are then driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    iWrEn = 1'b1; iWrAddr = a; iWrData = d;
    tick();
    iWrEn = 1'b0;
  endtask

  task automatic test_reset();
    nRst = 1'b0; iReq = 1'b0; iAddr = '0; iRespReady = 1'b1; iFlush = 1'b0;
    iWrEn = 1'b0; iWrAddr = '0; iWrData = '0;
    tick(); tick();
    checks++;
    if (oValid !== 1'b0 || oIns !== 32'h0 || oRespAddr !== 32'h0 || oFault !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b ins=%h addr=%h fault=%b required 0/0/0/0",
               oValid, oIns, oRespAddr, oFault);
    end
    checks++;
    if (oReady !== 1'b1) begin
      failures++; $display("FAIL reset_ready: got %b required 1", oReady);
    end
    iFlush = 1'b1; #1;
    checks++;
    if (oReady !== 1'b0) begin
      failures++; $display("FAIL reset_ready_flush: got %b required 0", oReady);
    end
    iFlush = 1'b0;
    nRst = 1'b1;
    tick();
  endtask

  task automatic test_normal_fetch();
    load_word(32'h8, 32'h0050_0093);
    iReq = 1'b1; iAddr = 32'h8; iRespReady = 1'b1; #1;
    checks++;
    if (oReady !== 1'b1) begin
      failures++; $display("FAIL fetch8_ready: got %b required 1", oReady);
    end
    tick();                       // accepting edge
    iReq = 1'b0; iAddr = '0;
    checks++;
    if (oValid !== 1'b0 || oIns !== 32'h0) begin
      failures++; $display("FAIL fetch8_early: valid=%b ins=%h required 0/0", oValid, oIns);
    end
    tick();
    checks++;
    if (oValid !== 1'b1 || oIns !== 32'h0050_0093 || oRespAddr !== 32'h8 || oFault !== 1'b0) begin
      failures++;
      $display("FAIL fetch8_resp: valid=%b ins=%h addr=%h fault=%b required 1/00500093/00000008/0",
               oValid, oIns, oRespAddr, oFault);
    end
    tick();                       // consumed with iRespReady=1
    checks++;
    if (oValid !== 1'b0 || oIns !== 32'h0) begin
      failures++; $display("FAIL fetch8_done: valid=%b ins=%h required 0/0", oValid, oIns);
    end
  endtask

  task automatic test_fault();
    logic [31:0] addrs [2];
    addrs[0] = 32'h6; addrs[1] = 32'h1000;
    for (int i = 0; i < 2; i++) begin
      iReq = 1'b1; iAddr = addrs[i]; iRespReady = 1'b1;
      tick();
      iReq = 1'b0;
      checks++;
      if (oValid !== 1'b0) begin
        failures++; $display("FAIL fault_early[%0d]: valid=%b required 0", i, oValid);
      end
      tick();
      checks++;
      if (oValid !== 1'b1 || oIns !== 32'h0000_0013 || oFault !== 1'b1 || oRespAddr !== addrs[i]) begin
        failures++;
        $display("FAIL fault_resp[%0d]: valid=%b ins=%h fault=%b addr=%h required 1/00000013/1/%h",
                 i, oValid, oIns, oFault, oRespAddr, addrs[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    load_word(32'hC, 32'h1122_3344);
    iReq = 1'b1; iAddr = 32'h8; iRespReady = 1'b0;
    tick();
    iAddr = 32'hC;                // keep requesting 0xC while the response is held
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (oValid !== 1'b1 || oIns !== 32'h0050_0093 || oRespAddr !== 32'h8 ||
          oFault !== 1'b0 || oReady !== 1'b0) begin
        failures++;
        $display("FAIL hold[%0d]: valid=%b ins=%h addr=%h fault=%b ready=%b required 1/00500093/00000008/0/0",
                 i, oValid, oIns, oRespAddr, oFault, oReady);
      end
      tick();
    end
    iRespReady = 1'b1; #1;
    checks++;
    if (oReady !== 1'b1) begin
      failures++; $display("FAIL b2b_ready: got %b required 1", oReady);
    end
    tick();
    iReq = 1'b0;
    checks++;
    if (oValid !== 1'b0) begin
      failures++; $display("FAIL b2b_gap: valid=%b required 0", oValid);
    end
    tick();
    checks++;
    if (oValid !== 1'b1 || oIns !== 32'h1122_3344 || oRespAddr !== 32'hC) begin
      failures++;
      $display("FAIL b2b_resp: valid=%b ins=%h addr=%h required 1/11223344/0000000c",
               oValid, oIns, oRespAddr);
    end
    tick();
  endtask

  task automatic test_flush();
    load_word(32'h10, 32'hAAAA_0001);
    load_word(32'h14, 32'hBBBB_0002);
    iReq = 1'b1; iAddr = 32'h10; iRespReady = 1'b1;
    tick();
    iReq = 1'b0; iFlush = 1'b1; #1;
    checks++;
    if (oReady !== 1'b0) begin
      failures++; $display("FAIL flush_ready: got %b required 0", oReady);
    end
    tick();
    iFlush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (oValid !== 1'b0) begin
        failures++; $display("FAIL flush_novalid[%0d]: valid=%b required 0", i, oValid);
      end
      tick();
    end
    iReq = 1'b1; iAddr = 32'h14;
    tick();
    iReq = 1'b0;
    tick();
    checks++;
    if (oValid !== 1'b1 || oIns !== 32'hBBBB_0002 || oRespAddr !== 32'h14) begin
      failures++;
      $display("FAIL flush_next: valid=%b ins=%h addr=%h required 1/bbbb0002/00000014",
               oValid, oIns, oRespAddr);
    end
    tick();
  endtask

  task automatic test_write_collision();
    load_word(32'h4, 32'h0123_4567);
    iReq = 1'b1; iAddr = 32'h4; iRespReady = 1'b1;
    iWrEn = 1'b1; iWrAddr = 32'h4; iWrData = 32'hDEAD_BEEF;
    tick();
    iReq = 1'b0; iWrEn = 1'b0;
    tick();
    checks++;
    if (oValid !== 1'b1 || oIns !== 32'h0123_4567) begin
      failures++; $display("FAIL wr_same_cycle: valid=%b ins=%h required 1/01234567", oValid, oIns);
    end
    iReq = 1'b1; iAddr = 32'h4;    // back-to-back re-fetch
    tick();
    iReq = 1'b0;
    tick();
    checks++;
    if (oValid !== 1'b1 || oIns !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL wr_refetch: valid=%b ins=%h required 1/deadbeef", oValid, oIns);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    iReq = 1'b1; iAddr = 32'h8; iRespReady = 1'b1;
    tick();
    iReq = 1'b0;
    nRst = 1'b0; #1;
    checks++;
    if (oValid !== 1'b0 || oIns !== 32'h0 || oRespAddr !== 32'h0) begin
      failures++;
      $display("FAIL rst_wait: valid=%b ins=%h addr=%h required 0/0/0", oValid, oIns, oRespAddr);
    end
    tick();
    nRst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (oValid !== 1'b0) begin
        failures++; $display("FAIL rst_noresp[%0d]: valid=%b required 0", i, oValid);
      end
    end
    iReq = 1'b1; iAddr = 32'h8;
    tick();
    iReq = 1'b0;
    tick();
    checks++;
    if (oValid !== 1'b1 || oIns !== 32'h0050_0093) begin
      failures++; $display("FAIL rst_mem_kept: valid=%b ins=%h required 1/00500093", oValid, oIns);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_normal_fetch();
    test_fault();
    test_back_to_back();
    test_flush();
    test_write_collision();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
